// File: rtl/imem_block_responder.sv
// Instruction memory behind the I-cache refill port: 64 x 128-bit blocks, fixed access latency, byte load port.
// Define IMEM_PREFETCH_EN to add a one-block next-line prefetch buffer.
module imem_block_responder #(
  parameter int LATENCY      = 4,
  parameter int BLOCK_ADDR_W = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      read,
  input  logic [BLOCK_ADDR_W-1:0]   address,
  output logic                      busywait,
  output logic [127:0]              readdata,
  input  logic                      load_en,
  input  logic [BLOCK_ADDR_W+3:0]   load_addr,
  input  logic [7:0]                load_byte
);

  localparam int          BYTES  = 16 << BLOCK_ADDR_W;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

`ifdef IMEM_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE, PREFETCH} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

  logic [7:0]              mem [0:BYTES-1];
  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [BLOCK_ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [127:0]            readdata_q, readdata_d;
  logic [BLOCK_ADDR_W-1:0] rd_sel;
  logic [127:0]            rd_block;

`ifdef IMEM_PREFETCH_EN
  logic [127:0]            pf_buf_q, pf_buf_d;
  logic                    pf_valid_q, pf_valid_d;
  logic [BLOCK_ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic                    wr_pf_blk;

  assign wr_pf_blk = load_en && (load_addr[BLOCK_ADDR_W+3:4] == pf_addr_q);
  // While prefetching, the array read port serves the prefetch target.
  assign rd_sel    = (state_q == PREFETCH) ? pf_addr_q : req_addr_q;
`else
  assign rd_sel    = req_addr_q;
`endif

  always_comb begin
    rd_block = '0;
    for (int k = 0; k < 16; k++)
      rd_block[8*k +: 8] = mem[{rd_sel, k[3:0]}];
  end

  always_comb begin
    busywait = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:     busywait = read;
        BUSY:     busywait = 1'b1;
`ifdef IMEM_PREFETCH_EN
        PREFETCH: busywait = read;
`endif
        default:  busywait = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    readdata_d = readdata_q;
`ifdef IMEM_PREFETCH_EN
    pf_buf_d   = pf_buf_q;
    pf_valid_d = pf_valid_q;
    pf_addr_d  = pf_addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (read) begin
          req_addr_d = address;
`ifdef IMEM_PREFETCH_EN
          if (pf_valid_q && (address == pf_addr_q) && !wr_pf_blk) begin
            readdata_d = pf_buf_q;
            state_d    = DONE;
          end else begin
            cnt_d   = LAT_M1;
            state_d = BUSY;
          end
`else
          cnt_d   = LAT_M1;
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        if (!read) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          readdata_d = rd_block;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
`ifdef IMEM_PREFETCH_EN
        pf_addr_d  = req_addr_q + BLOCK_ADDR_W'(1);
        pf_valid_d = 1'b0;
        cnt_d      = LAT_M1;
        state_d    = PREFETCH;
`else
        state_d = IDLE;
`endif
      end
`ifdef IMEM_PREFETCH_EN
      PREFETCH: begin
        if (read && (address != pf_addr_q)) begin
          req_addr_d = address;
          cnt_d      = LAT_M1;
          state_d    = BUSY;
        end else if (cnt_q == 4'd0) begin
          pf_buf_d   = rd_block;
          pf_valid_d = 1'b1;
          if (read) begin
            req_addr_d = address;
            readdata_d = rd_block;
            state_d    = DONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef IMEM_PREFETCH_EN
    // A load into the buffered block makes the buffered copy stale.
    if (wr_pf_blk)
      pf_valid_d = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      readdata_q <= '0;
`ifdef IMEM_PREFETCH_EN
      pf_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
`ifdef IMEM_PREFETCH_EN
      pf_valid_q <= pf_valid_d;
`endif
    end
    req_addr_q <= req_addr_d;
`ifdef IMEM_PREFETCH_EN
    pf_buf_q   <= pf_buf_d;
    pf_addr_q  <= pf_addr_d;
`endif
  end

  always_ff @(posedge clock) begin
    if (load_en)
      mem[load_addr] <= load_byte;
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_imem_block_responder.sv
// Bench for imem_block_responder: byte-array reference model, handshake latency and load-port timing.
module tb_imem_block_responder;
  localparam int LAT = 4;

  logic         clock = 1'b0;
  logic         reset, read, busywait, load_en;
  logic [5:0]   address;
  logic [127:0] readdata;
  logic [9:0]   load_addr;
  logic [7:0]   load_byte;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] ref_mem [0:1023];

  imem_block_responder #(.LATENCY(LAT), .BLOCK_ADDR_W(6)) dut (
    .clock(clock), .reset(reset), .read(read), .address(address),
    .busywait(busywait), .readdata(readdata), .load_en(load_en),
    .load_addr(load_addr), .load_byte(load_byte)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] exp_block(input logic [5:0] b);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_mem[int'(b) * 16 + k];
    return r;
  endfunction

  task automatic load_one(input logic [9:0] a, input logic [7:0] v);
    @(negedge clock);
    load_en = 1'b1; load_addr = a; load_byte = v;
    @(negedge clock);
    load_en = 1'b0;
    ref_mem[a] = v;
  endtask

  // Raises read, optionally writes a byte at edge wr_at and changes address at cycle chg_at;
  // returns the number of cycles busywait was high. Leaves the clock in the DONE cycle.
  task automatic do_read(input logic [5:0] a, input int wr_at, input logic [9:0] wa,
                         input logic [7:0] wb, input int chg_at, input logic [5:0] ca,
                         output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      read = 1'b1;
      if (k == 0) address = a;
      else if (k == chg_at) address = ca;
      load_en = (k == wr_at); load_addr = wa; load_byte = wb;
      #1;
      if (!busywait) begin ok = 1'b1; break; end
      cyc++;
    end
    read = 1'b0; load_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; read = 1'b1; address = 6'd2;
    repeat (3) @(negedge clock);
    #1;
    vectors++;
    if (busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait got %b want 0", busywait); end
    vectors++;
    if (readdata !== 128'd0) begin errors++; $display("FAIL reset_readdata got %h want 0", readdata); end
    reset = 1'b0; read = 1'b0;
  endtask

  task automatic fill_memory();
    for (int i = 0; i < 1024; i++) begin
      @(negedge clock);
      load_en = 1'b1; load_addr = 10'(i); load_byte = 8'($urandom);
      ref_mem[i] = load_byte;
    end
    @(negedge clock);
    load_en = 1'b0;
    for (int i = 0; i < 16; i++) load_one(10'(i), 8'(i));
  endtask

  task automatic test_basic();
    int cyc; bit ok;
    do_read(6'd0, -1, 10'd0, 8'd0, -1, 6'd0, cyc, ok);
    vectors++;
    if (cyc != LAT + 1 || !ok) begin errors++; $display("FAIL basic_latency got %0d want %0d", cyc, LAT + 1); end
    vectors++;
    if (readdata !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
      errors++; $display("FAIL basic_data got %h want 0f0e..0100", readdata);
    end
    // Next cycle is no longer DONE: a raised read must see busywait high again.
    @(negedge clock);
    read = 1'b1; #1;
    vectors++;
    if (busywait !== 1'b1) begin errors++; $display("FAIL done_one_cycle got %b want 1", busywait); end
    read = 1'b0;
  endtask

  task automatic test_abort();
    logic [127:0] prev;
    int cyc; bit ok;
    prev = readdata;
    @(negedge clock);
    read = 1'b1; address = 6'd3;
    repeat (3) @(negedge clock);
    read = 1'b0;
    repeat (LAT + 3) @(negedge clock);
    #1;
    vectors++;
    if (readdata !== prev) begin errors++; $display("FAIL abort_hold got %h want %h", readdata, prev); end
    vectors++;
    if (busywait !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", busywait); end
    do_read(6'd3, -1, 10'd0, 8'd0, -1, 6'd0, cyc, ok);
    vectors++;
    if (cyc != LAT + 1 || readdata !== exp_block(6'd3)) begin
      errors++; $display("FAIL abort_next got %0d/%h want %0d/%h", cyc, readdata, LAT + 1, exp_block(6'd3));
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok;
    @(negedge clock);
    read = 1'b1; address = 6'd7;
    repeat (2) @(negedge clock);
    reset = 1'b1; #1;
    vectors++;
    if (busywait !== 1'b0) begin errors++; $display("FAIL midreset_busywait got %b want 0", busywait); end
    @(negedge clock); #1;
    vectors++;
    if (readdata !== 128'd0) begin errors++; $display("FAIL midreset_readdata got %h want 0", readdata); end
    vectors++;
    if (busywait !== 1'b0) begin errors++; $display("FAIL midreset_busywait2 got %b want 0", busywait); end
    reset = 1'b0; read = 1'b0;
    do_read(6'd7, -1, 10'd0, 8'd0, -1, 6'd0, cyc, ok);
    vectors++;
    if (cyc != LAT + 1 || readdata !== exp_block(6'd7)) begin
      errors++; $display("FAIL midreset_fresh got %0d/%h want %0d/%h", cyc, readdata, LAT + 1, exp_block(6'd7));
    end
  endtask

  task automatic test_addr_change();
    int cyc; bit ok;
    do_read(6'd5, -1, 10'd0, 8'd0, 2, 6'd9, cyc, ok);
    vectors++;
    if (readdata !== exp_block(6'd5)) begin
      errors++; $display("FAIL addr_change got %h want %h", readdata, exp_block(6'd5));
    end
    vectors++;
    if (cyc != LAT + 1) begin errors++; $display("FAIL addr_change_lat got %0d want %0d", cyc, LAT + 1); end
  endtask

  task automatic test_load_timing();
    int cyc; bit ok;
    logic [127:0] exp;
    ref_mem[10'h050] = 8'hAA;
    exp = exp_block(6'd5);
    do_read(6'd5, LAT - 2, 10'h050, 8'hAA, -1, 6'd0, cyc, ok);
    vectors++;
    if (readdata[7:0] !== 8'hAA) begin errors++; $display("FAIL load_early got %h want aa", readdata[7:0]); end
    vectors++;
    if (readdata !== exp) begin errors++; $display("FAIL load_early_blk got %h want %h", readdata, exp); end
    exp = exp_block(6'd5);
    do_read(6'd5, LAT, 10'h050, 8'h55, -1, 6'd0, cyc, ok);
    ref_mem[10'h050] = 8'h55;
    vectors++;
    if (readdata[7:0] !== 8'hAA) begin errors++; $display("FAIL load_at_capture got %h want aa", readdata[7:0]); end
    do_read(6'd5, -1, 10'd0, 8'd0, -1, 6'd0, cyc, ok);
    vectors++;
    if (readdata[7:0] !== 8'h55) begin errors++; $display("FAIL load_after got %h want 55", readdata[7:0]); end
  endtask

  task automatic test_random();
    int cyc, wr_at, chg_at; bit ok;
    logic [5:0] a, ca;
    logic [9:0] wa;
    logic [7:0] wb;
    logic [127:0] exp;
    for (int it = 0; it < 24; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 2)); w++)
        load_one(10'($urandom), 8'($urandom));
      a  = 6'($urandom);
      ca = 6'($urandom);
      wa = {a, 4'($urandom)};
      wb = ~ref_mem[wa];
`ifdef IMEM_PREFETCH_EN
      wr_at = -1; chg_at = -1;
`else
      wr_at  = int'($urandom_range(0, LAT + 1)) - 1;
      chg_at = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, LAT));
`endif
      if (wr_at >= 0 && wr_at < LAT) ref_mem[wa] = wb;
      exp = exp_block(a);
      do_read(a, wr_at, wa, wb, chg_at, ca, cyc, ok);
      if (wr_at == LAT) ref_mem[wa] = wb;
      vectors++;
      if (readdata !== exp) begin errors++; $display("FAIL rand_data blk %0d got %h want %h", a, readdata, exp); end
      vectors++;
      if (!ok) begin errors++; $display("FAIL rand_timeout blk %0d busywait stuck high", a); end
`ifndef IMEM_PREFETCH_EN
      vectors++;
      if (cyc != LAT + 1) begin errors++; $display("FAIL rand_latency got %0d want %0d", cyc, LAT + 1); end
`endif
    end
  endtask

`ifdef IMEM_PREFETCH_EN
  task automatic test_prefetch();
    int cyc; bit ok;
    do_read(6'd63, -1, 10'd0, 8'd0, -1, 6'd0, cyc, ok);
    repeat (LAT + 2) @(negedge clock);
    do_read(6'd0, -1, 10'd0, 8'd0, -1, 6'd0, cyc, ok);
    vectors++;
    if (cyc != 1) begin errors++; $display("FAIL pf_hit_latency got %0d want 1", cyc); end
    vectors++;
    if (readdata !== exp_block(6'd0)) begin errors++; $display("FAIL pf_hit_data got %h want %h", readdata, exp_block(6'd0)); end
    do_read(6'd63, -1, 10'd0, 8'd0, -1, 6'd0, cyc, ok);
    repeat (LAT + 2) @(negedge clock);
    load_one(10'h007, 8'hC3);
    do_read(6'd0, -1, 10'd0, 8'd0, -1, 6'd0, cyc, ok);
    vectors++;
    if (cyc != LAT + 1) begin errors++; $display("FAIL pf_inval_latency got %0d want %0d", cyc, LAT + 1); end
    vectors++;
    if (readdata !== exp_block(6'd0)) begin errors++; $display("FAIL pf_inval_data got %h want %h", readdata, exp_block(6'd0)); end
  endtask
`endif

  initial begin
    reset = 1'b1; read = 1'b0; address = '0;
    load_en = 1'b0; load_addr = '0; load_byte = '0;
    test_reset();
    fill_memory();
    test_basic();
    test_abort();
    test_reset_mid();
    test_addr_change();
    test_load_timing();
    test_random();
`ifdef IMEM_PREFETCH_EN
    test_prefetch();
`endif
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
